// File: rtl/multi_channel_timer.sv
// Multi-channel scheduled timer: N_CH programmable daily-style channels plus one manual channel.
// Front-panel buttons are synchronised and edge-detected here; time base from an internal prescaler.
module multi_channel_timer #(
  parameter int unsigned N_CH     = 2,
  parameter int unsigned TW       = 5,
  parameter int unsigned PERIOD   = 24,
  parameter int unsigned TICK_DIV = 1,
  localparam int unsigned SW      = $clog2(3 * N_CH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            b_sel,
  input  logic            b_inc,
  input  logic            b_man_dur,
  input  logic            man_trig,
  output logic [N_CH-1:0] ch_out,
  output logic            any_out,
  output logic            man_out,
  output logic [TW-1:0]   time_now,
  output logic [SW-1:0]   sel_field
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {StIdle, StActive} state_e;

  // Button order: [0] b_sel, [1] b_inc, [2] b_man_dur, [3] man_trig
  logic [3:0] btn, sync1_q, sync2_q, prev_q, pulse;

  assign btn   = {man_trig, b_man_dur, b_inc, b_sel};
  assign pulse = sync2_q & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  logic [PW-1:0] presc_q;
  logic          tick;
  logic [TW-1:0] time_q, next_t;

  assign tick   = (presc_q == PW'(TICK_DIV - 1));
  assign next_t = (time_q == TW'(PERIOD - 1)) ? '0 : time_q + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      time_q  <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) time_q <= next_t;
    end
  end

  logic [N_CH-1:0][TW-1:0] start_q, dur_q;
  logic [N_CH-1:0]         en_q;
  logic [TW-1:0]           man_dur_q;
  logic [SW-1:0]           sel_q;

  // Increment acts on the pre-advance selection when both pulses coincide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_q   <= '0;
      dur_q     <= '0;
      en_q      <= '0;
      man_dur_q <= '0;
      sel_q     <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (pulse[1] && sel_q == SW'(3 * i))     start_q[i] <= start_q[i] + 1'b1;
        if (pulse[1] && sel_q == SW'(3 * i + 1)) dur_q[i]   <= dur_q[i] + 1'b1;
        if (pulse[1] && sel_q == SW'(3 * i + 2)) en_q[i]    <= ~en_q[i];
      end
      if (pulse[2]) man_dur_q <= man_dur_q + 1'b1;
      if (pulse[0]) sel_q <= (sel_q == SW'(3 * N_CH - 1)) ? '0 : sel_q + 1'b1;
    end
  end

  state_e                  ch_st_q [N_CH];
  logic [N_CH-1:0][TW-1:0] ch_rem_q;
  logic [N_CH-1:0]         ch_out_q, ch_out_d, start_hit, expire;
  logic                    any_q;

  always_comb begin
    start_hit = '0;
    expire    = '0;
    ch_out_d  = ch_out_q;
    for (int unsigned i = 0; i < N_CH; i++) begin
      start_hit[i] = (next_t == start_q[i]) && (dur_q[i] != '0);
      expire[i]    = (ch_st_q[i] == StActive) && (ch_rem_q[i] == TW'(1));
      if (!en_q[i])                 ch_out_d[i] = 1'b0;
      else if (tick && start_hit[i]) ch_out_d[i] = 1'b1;
      else if (tick && expire[i])    ch_out_d[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) ch_st_q[i] <= StIdle;
      ch_rem_q <= '0;
      ch_out_q <= '0;
      any_q    <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (!en_q[i]) begin
          ch_st_q[i] <= StIdle;
        end else if (tick) begin
          if (start_hit[i]) begin
            ch_st_q[i]  <= StActive;
            ch_rem_q[i] <= dur_q[i];
          end else if (expire[i]) begin
            ch_st_q[i] <= StIdle;
          end else if (ch_st_q[i] == StActive) begin
            ch_rem_q[i] <= ch_rem_q[i] - 1'b1;
          end
        end
      end
      ch_out_q <= ch_out_d;
      any_q    <= |ch_out_d;
    end
  end

  state_e        man_st_q;
  logic [TW-1:0] man_rem_q;
  logic          man_out_q;

  // Trigger wins over a coincident tick; no retrigger while active
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      man_st_q  <= StIdle;
      man_rem_q <= '0;
      man_out_q <= 1'b0;
    end else if (pulse[3] && man_st_q == StIdle && man_dur_q != '0) begin
      man_st_q  <= StActive;
      man_rem_q <= man_dur_q;
      man_out_q <= 1'b1;
    end else if (tick && man_st_q == StActive) begin
      if (man_rem_q == TW'(1)) begin
        man_st_q  <= StIdle;
        man_out_q <= 1'b0;
      end else begin
        man_rem_q <= man_rem_q - 1'b1;
      end
    end
  end

  assign ch_out    = ch_out_q;
  assign any_out   = any_q;
  assign man_out   = man_out_q;
  assign time_now  = time_q;
  assign sel_field = sel_q;

endmodule

// File: tb/tb_multi_channel_timer.sv
// Self-checking bench for multi_channel_timer: directed programming plus random button traffic,
// compared every cycle against a tick-level behavioural model.
module tb_multi_channel_timer;

  localparam int unsigned N_CH     = 2;
  localparam int unsigned TW       = 5;
  localparam int unsigned PERIOD   = 24;
  localparam int unsigned TICK_DIV = 1;
  localparam int unsigned SW       = $clog2(3 * N_CH);
  localparam int          FMOD     = 1 << TW;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            b_sel = 1'b0, b_inc = 1'b0, b_man_dur = 1'b0, man_trig = 1'b0;
  logic [N_CH-1:0] ch_out;
  logic            any_out, man_out;
  logic [TW-1:0]   time_now;
  logic [SW-1:0]   sel_field;

  multi_channel_timer #(
    .N_CH    (N_CH),
    .TW      (TW),
    .PERIOD  (PERIOD),
    .TICK_DIV(TICK_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .b_sel    (b_sel),
    .b_inc    (b_inc),
    .b_man_dur(b_man_dur),
    .man_trig (man_trig),
    .ch_out   (ch_out),
    .any_out  (any_out),
    .man_out  (man_out),
    .time_now (time_now),
    .sel_field(sel_field)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: remaining high ticks per channel (0 = off), sampled button history per button
  int       m_time, m_sel, m_man_dur, m_man_rem, m_cyc;
  int       m_start [N_CH];
  int       m_dur   [N_CH];
  int       m_rem   [N_CH];
  bit       m_en    [N_CH];
  bit [3:0] hist    [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_time = 0; m_sel = 0; m_man_dur = 0; m_man_rem = 0; m_cyc = 0;
    for (int i = 0; i < N_CH; i++) begin
      m_start[i] = 0; m_dur[i] = 0; m_rem[i] = 0; m_en[i] = 1'b0;
    end
    for (int b = 0; b < 4; b++) hist[b] = '0;
  endtask

  // lv bits: [0] b_sel, [1] b_inc, [2] b_man_dur, [3] man_trig, as sampled on this edge
  task automatic model_edge(input bit [3:0] lv);
    bit [3:0] p;
    bit       tk;
    int       nt, f, k;
    for (int b = 0; b < 4; b++) begin
      hist[b] = {hist[b][2:0], lv[b]};
      // a level first seen high two edges ago takes effect now
      p[b] = hist[b][2] && !hist[b][3];
    end
    tk = (m_cyc % TICK_DIV) == (TICK_DIV - 1);
    nt = (m_time + 1) % PERIOD;
    for (int i = 0; i < N_CH; i++) begin
      if (!m_en[i]) m_rem[i] = 0;
      else if (tk) begin
        if (nt == m_start[i] && m_dur[i] != 0) m_rem[i] = m_dur[i];
        else if (m_rem[i] > 0) m_rem[i]--;
      end
    end
    if (p[3] && m_man_rem == 0 && m_man_dur != 0) m_man_rem = m_man_dur;
    else if (tk && m_man_rem > 0) m_man_rem--;
    if (tk) m_time = nt;
    if (p[1]) begin
      f = m_sel / 3;
      k = m_sel % 3;
      if (k == 0) m_start[f] = (m_start[f] + 1) % FMOD;
      else if (k == 1) m_dur[f] = (m_dur[f] + 1) % FMOD;
      else m_en[f] = !m_en[f];
    end
    if (p[2]) m_man_dur = (m_man_dur + 1) % FMOD;
    if (p[0]) m_sel = (m_sel + 1) % (3 * N_CH);
    m_cyc++;
  endtask

  task automatic compare_all();
    logic [N_CH-1:0] exp_ch;
    exp_ch = '0;
    for (int i = 0; i < N_CH; i++) exp_ch[i] = (m_rem[i] != 0);
    check("ch_out", 32'(ch_out), 32'(exp_ch));
    check("any_out", 32'(any_out), 32'(|exp_ch));
    check("man_out", 32'(man_out), 32'(m_man_rem != 0));
    check("time_now", 32'(time_now), 32'(m_time));
    check("sel_field", 32'(sel_field), 32'(m_sel));
  endtask

  task automatic step(input bit [3:0] lv);
    b_sel     = lv[0];
    b_inc     = lv[1];
    b_man_dur = lv[2];
    man_trig  = lv[3];
    @(posedge clk);
    model_edge(lv);
    #1;
    compare_all();
  endtask

  task automatic press(input bit [3:0] lv, input int times);
    for (int n = 0; n < times; n++) begin
      step(lv);
      step(4'b0000);
    end
  endtask

  task automatic idle(input int cycles);
    for (int n = 0; n < cycles; n++) step(4'b0000);
  endtask

  // Called just after a compare; reset is asserted and released between clock edges
  task automatic async_reset();
    #1 rst = 1'b1;
    #1;
    check("rst_ch_out", 32'(ch_out), 32'd0);
    check("rst_any_out", 32'(any_out), 32'd0);
    check("rst_man_out", 32'(man_out), 32'd0);
    check("rst_time_now", 32'(time_now), 32'd0);
    check("rst_sel_field", 32'(sel_field), 32'd0);
    #1 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    #1;
    compare_all();
    @(posedge clk);
    #1 rst = 1'b0;

    // Simultaneous sel+inc at field 0: start0 becomes 1, selection moves to 1
    press(4'b0011, 1);
    press(4'b0001, 5);
    // ch0 start=3, dur=2, enable
    press(4'b0010, 2);
    press(4'b0001, 1);
    press(4'b0010, 2);
    press(4'b0001, 1);
    press(4'b0010, 1);
    idle(60);
    // Wrap-around window: start 23, dur 3
    press(4'b0001, 4);
    press(4'b0010, 20);
    press(4'b0001, 1);
    press(4'b0010, 1);
    idle(60);
    // Disable mid-window, then re-enable
    press(4'b0001, 1);
    idle(6);
    press(4'b0010, 1);
    idle(5);
    press(4'b0010, 1);
    idle(40);
    // Manual channel: dur 3, trigger, retrigger mid-pulse
    press(4'b0100, 3);
    press(4'b1000, 1);
    step(4'b0000);
    press(4'b1000, 1);
    idle(10);
    // Manual duration wrapped to 0 never fires
    press(4'b0100, FMOD - 3);
    press(4'b1000, 1);
    idle(10);

    async_reset();
    for (int n = 0; n < 4000; n++) begin
      bit [3:0] lv;
      lv[0] = ($urandom_range(0, 5) == 0);
      lv[1] = ($urandom_range(0, 3) == 0);
      lv[2] = ($urandom_range(0, 9) == 0);
      lv[3] = ($urandom_range(0, 11) == 0);
      step(lv);
      if (n == 2000) async_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_channel_timer.md
Name: multi_channel_timer

Overview:
- Parametrised successor of the two-program single-output appliance timer: N_CH independently scheduled channels plus one manual/emergency channel, all on a single clock.
- Buttons (select field, increment, manual duration, manual trigger) are synchronised and edge-detected inside the block; time base comes from an internal prescaler.
- Sits between the front-panel button inputs and the load drivers. Each channel has its own output and a combined OR output.

Parameters:
- N_CH, 2, number of scheduled channels (1..8).
- TW, 5, width of time, start and duration fields.
- PERIOD, 24, time counter modulus in ticks (2..2^TW).
- TICK_DIV, 1, clk cycles per tick (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- b_sel  in  1  field-select button; async, pre-debounced.
- b_inc  in  1  increment/toggle selected field.
- b_man_dur  in  1  increment manual-channel duration.
- man_trig  in  1  manual-channel trigger.
- ch_out  out  N_CH  scheduled channel outputs, bit i = channel i.
- any_out  out  1  OR of ch_out.
- man_out  out  1  manual channel output.
- time_now  out  TW  current time count.
- sel_field  out  $clog2(3*N_CH)  index of the field being edited.

Behaviour:
- Reset values (async, all regs): ch_out=0, any_out=0, man_out=0, time_now=0, sel_field=0, prescaler=0. All start, duration, enable and man_dur fields are 0; synchroniser and edge regs are 0.
- Inputs:
  - Each button passes through a 2-FF synchroniser, then a rising-edge detector, giving a one-cycle pulse.
  - The resulting config/trigger effect lands on the 3rd clk edge after the first edge that samples the input high.
- Field map: sel_field = 3*i + k for channel i, where k=0 is start, k=1 is duration, k=2 is enable.
- b_sel pulse: sel_field increments and wraps from 3*N_CH-1 to 0.
- b_inc pulse:
  - On a start or duration field: field+1, wrapping mod 2^TW.
  - On an enable field: the enable bit toggles.
- Same-cycle b_sel and b_inc pulses: the increment applies to the old selection, then the selection advances.
- b_man_dur pulse: man_dur+1, wrapping mod 2^TW.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick is the cycle where the count is TICK_DIV-1.
  - TICK_DIV=1 means tick on every cycle.
- Time counter: on a tick edge, time_now becomes next_t = (time_now==PERIOD-1) ? 0 : time_now+1.
- Per-channel FSM, states IDLE and ACTIVE, 4-bit-agnostic remaining counter of width TW. Evaluated on tick edges in this priority order:
  1. enable=0: go to IDLE and clear the output. This also applies off-tick, taking effect on the next clk edge after the enable clears.
  2. next_t==start and duration!=0: go to ACTIVE, remaining=duration, output=1. If already ACTIVE this is a retrigger and reloads.
  3. ACTIVE with remaining==1: go to IDLE, output=0.
  4. ACTIVE otherwise: remaining-1.
- Per-channel FSM consequences:
  - The output is high for exactly `duration` tick periods, starting with the period in which time_now==start.
  - duration=0 never activates.
  - Editing duration or start while ACTIVE does not change the remaining count.
  - A config write on the same edge as a tick is compared using the pre-write value.
- Manual channel FSM, IDLE/ACTIVE:
  - man_trig pulse while IDLE with man_dur!=0: go to ACTIVE, remaining=man_dur, man_out=1 on that edge.
  - man_trig pulse while ACTIVE is ignored (no retrigger).
  - On tick edges while ACTIVE: remaining==1 goes to IDLE with man_out=0; otherwise remaining-1.
  - The first period may be partial, so high time is between man_dur-1 and man_dur ticks. It is exactly man_dur ticks when TICK_DIV=1.
  - If the trigger pulse and a tick coincide, activation wins and no decrement happens that edge.
- any_out is registered, equals OR of the ch_out next-state values, and has the same timing as ch_out.
- rst mid-operation: all outputs drop asynchronously and all configuration is lost.

Test Plan:
1. N_CH=2, TICK_DIV=1. rst, then program ch0 start=3, dur=2, en=1 via b_sel/b_inc -> ch_out[0] and any_out are high exactly while time_now is 3 and 4; ch_out[1] stays 0.
2. ch0 start=PERIOD-1=23, dur=3 -> high for time_now 23, 0, 1 (wrap-around); low at 2.
3. ch0 start=5, dur=0, en=1 -> ch_out[0] never rises over 2 full periods. Then set dur=4 while time_now=10 -> activates at the next pass of 5.
4. ch0 active (start=2, dur=6); clear en at time_now=4 -> ch_out[0]=0 one clk after the enable write. Re-enable -> no activation until the next start match.
5. man_dur=3, pulse man_trig -> man_out high 3 cycles later for 3 ticks. A second man_trig mid-pulse does not extend it. man_dur=0 with a trigger -> no pulse.
6. Press b_sel and b_inc in the same cycle with sel_field=0 -> ch0 start=1 and sel_field=1. Assert rst with ch0 active -> ch_out=0 and time_now=0 immediately, with no clk edge needed.
